// File: rtl/dino_pkg.sv
// Shared constants and types for the dino game: screen geometry, the obstacle
// state encoding and the spawn LFSR definition.
package dino_pkg;
  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 16;
  localparam int DINO_X   = 48;
  localparam int GAP_W    = 8;

  typedef enum logic [1:0] {IDLE, WAIT, MOVE, FROZEN} obs_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of the polynomial map to bit indices 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/obs_ctrl_if.sv
// Frame/control inputs and obstacle outputs of obs_ctrl, bundled for the
// game top; xpos width follows the renderer's coordinate shift.
interface obs_ctrl_if #(parameter int CONV = 0);
  logic            i_frame_tick;
  logic            i_start;
  logic            i_crash;
  logic [9:CONV]   o_xpos;
  logic            o_active;
  logic            o_pass;
  logic [3:0]      o_speed;

  modport master (
    output i_frame_tick, i_start, i_crash,
    input  o_xpos, o_active, o_pass, o_speed
  );

  modport slave (
    input  i_frame_tick, i_start, i_crash,
    output o_xpos, o_active, o_pass, o_speed
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; reloads its nonzero seed on reset so it
// never locks up at zero.
module lfsr8
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);
  always_ff @(posedge clk) begin
    if (rst) state <= LFSR_SEED;
    else     state <= lfsr8_next(state);
  end
endmodule

// File: rtl/obs_ctrl.sv
// Obstacle motion controller: spawn off-screen right, scroll left per frame,
// despawn with a random gap, pass pulses with a speed ramp, freeze on crash.
module obs_ctrl #(
  parameter int CONV       = 0,
  parameter int SCREEN_W   = dino_pkg::SCREEN_W,
  parameter int SPRITE_W   = dino_pkg::SPRITE_W,
  parameter int DINO_X     = dino_pkg::DINO_X,
  parameter int MIN_GAP    = 30,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8
) (
  input  logic     clk,
  input  logic     rst,
  obs_ctrl_if.slave bus
);
  import dino_pkg::*;

  localparam int         W        = 10 - CONV;
  localparam logic [W-1:0] SPAWN_X = W'((SCREEN_W + SPRITE_W) >> CONV);
  localparam logic [W-1:0] PASS_X  = W'(DINO_X >> CONV);
  localparam logic [3:0] SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0] SPD_MAX  = 4'(SPEED_MAX);

  obs_state_t       state, state_nxt;
  logic [W-1:0]     xpos, xpos_nxt, step_x;
  logic             active, active_nxt;
  logic             pass, pass_nxt;
  logic [3:0]       speed, speed_nxt;
  logic [GAP_W-1:0] gap, gap_nxt, fresh_gap;
  logic [2:0]       pcnt, pcnt_nxt;
  logic [7:0]       lfsr;
  logic             lfsr_unused;

  lfsr8 u_lfsr (.clk(clk), .rst(rst), .state(lfsr));

  assign lfsr_unused = ^lfsr[7:6];
  assign fresh_gap   = GAP_W'(MIN_GAP) + GAP_W'(lfsr[5:0]);
  // Clamp to zero instead of wrapping when the step would overshoot the edge
  assign step_x      = (xpos <= W'(speed)) ? '0 : xpos - W'(speed);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xpos   <= '0;
      active <= 1'b0;
      pass   <= 1'b0;
      speed  <= SPD_INIT;
      gap    <= '0;
      pcnt   <= '0;
    end else begin
      state  <= state_nxt;
      xpos   <= xpos_nxt;
      active <= active_nxt;
      pass   <= pass_nxt;
      speed  <= speed_nxt;
      gap    <= gap_nxt;
      pcnt   <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    xpos_nxt   = xpos;
    active_nxt = active;
    pass_nxt   = 1'b0;
    speed_nxt  = speed;
    gap_nxt    = gap;
    pcnt_nxt   = pcnt;
    unique case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_nxt = WAIT;
          gap_nxt   = fresh_gap;
          speed_nxt = SPD_INIT;
          pcnt_nxt  = '0;
        end
      end
      WAIT: begin
        if (bus.i_crash) begin
          state_nxt = FROZEN;
        end else if (bus.i_frame_tick) begin
          if (gap == '0) begin
            state_nxt  = MOVE;
            xpos_nxt   = SPAWN_X;
            active_nxt = 1'b1;
          end else begin
            gap_nxt = gap - GAP_W'(1);
          end
        end
      end
      MOVE: begin
        if (bus.i_crash) begin
          state_nxt = FROZEN;
        end else if (bus.i_frame_tick) begin
          xpos_nxt = step_x;
          if (step_x == '0) begin
            state_nxt  = WAIT;
            active_nxt = 1'b0;
            gap_nxt    = fresh_gap;
          end
          // Crossing test uses the clamped position so a despawn can still pulse
          if (xpos >= PASS_X && step_x < PASS_X) begin
            pass_nxt = 1'b1;
            pcnt_nxt = pcnt + 3'd1;
            if (pcnt == 3'd7)
              speed_nxt = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'd1;
          end
        end
      end
      FROZEN: begin
        if (bus.i_start) begin
          state_nxt  = WAIT;
          xpos_nxt   = '0;
          active_nxt = 1'b0;
          gap_nxt    = fresh_gap;
          speed_nxt  = SPD_INIT;
          pcnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_xpos   = xpos;
  assign bus.o_active = active;
  assign bus.o_pass   = pass;
  assign bus.o_speed  = speed;
endmodule
